// File: rtl/cfg_fetch_if.sv
// AXI4 read-channel bundle between cfg_fetch (master) and the HP read port (slave).
// Only the AR and R channels are carried; the block never writes.
interface cfg_fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] m_araddr;
  logic [7:0]            m_arlen;
  logic [2:0]            m_arsize;
  logic [1:0]            m_arburst;
  logic                  m_arvalid;
  logic                  m_arready;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic [1:0]            m_rresp;
  logic                  m_rlast;
  logic                  m_rvalid;
  logic                  m_rready;

  modport master (
    output m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
    input  m_arready, m_rdata, m_rresp, m_rlast, m_rvalid
  );

  modport slave (
    input  m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
    output m_arready, m_rdata, m_rresp, m_rlast, m_rvalid
  );
endinterface

// File: rtl/cfg_fetch.sv
// Single-beat AXI4 read of one 64-bit per-layer config word from the DDR table,
// unpacked into registered layer-control fields for the layer sequencer.
module cfg_fetch #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 64,
  parameter logic [ADDR_WIDTH-1:0] CFG_BASE    = 32'h0800_0000,
  parameter int                    IDX_WIDTH   = 8,
  parameter int                    TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_req,
  input  logic [IDX_WIDTH-1:0] cfg_idx,
  output logic                 cfg_busy,
  output logic                 cfg_vld,
  output logic                 cfg_err,
  output logic [8:0]           cfg_lenrow,
  output logic [7:0]           cfg_depblk,
  output logic [8:0]           cfg_numblk,
  output logic [7:0]           cfg_numfrm,
  output logic [4:0]           cfg_numpat,
  output logic [4:0]           cfg_numfilterg,
  output logic [4:0]           cfg_numlay,
  output logic [3:0]           cfg_prio,
  output logic [1:0]           cfg_stride,
  output logic [1:0]           cfg_pool_valifm,
  output logic [1:0]           cfg_fl,
  cfg_fetch_if.master          axi
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, AR, R, DONE, ERR} state_t;

  state_t                state, state_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic [58:0]           word;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  busy;
  logic                  accept, beat_ok, timeout;
  logic                  unused_bits;

  // Reserved word bits and rlast carry no information for this block.
  assign unused_bits = ^{axi.m_rlast, axi.m_rdata[DATA_WIDTH-1:59]};

  assign timeout = (cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign accept  = (state == IDLE) && cfg_req;
  assign beat_ok = (state == R) && axi.m_rvalid && (axi.m_rresp == 2'b00);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (cfg_req) state_nx = AR;
      end
      AR: begin
        if (axi.m_arready) begin
          state_nx = R;
          cnt_nx   = '0;
        end else if (timeout) begin
          state_nx = ERR;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      R: begin
        if (axi.m_rvalid) begin
          state_nx = (axi.m_rresp == 2'b00) ? DONE : ERR;
          cnt_nx   = '0;
        end else if (timeout) begin
          state_nx = ERR;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake strobes decode straight from state, so AR and R can never overlap.
  always_comb begin
    axi.m_arvalid = 1'b0;
    axi.m_rready  = 1'b0;
    cfg_vld       = 1'b0;
    cfg_err       = 1'b0;
    case (state)
      AR:      axi.m_arvalid = 1'b1;
      R:       axi.m_rready  = 1'b1;
      DONE:    cfg_vld       = 1'b1;
      ERR:     cfg_err       = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      araddr <= '0;
      word   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        busy   <= 1'b1;
        araddr <= CFG_BASE + ADDR_WIDTH'({cfg_idx, 3'b000});
      end else if (state == DONE || state == ERR) begin
        busy <= 1'b0;
      end
      if (beat_ok) word <= axi.m_rdata[58:0];
    end
  end

  assign cfg_busy      = busy;
  assign axi.m_araddr  = araddr;
  assign axi.m_arlen   = 8'd0;
  assign axi.m_arsize  = 3'($clog2(DATA_WIDTH / 8));
  assign axi.m_arburst = 2'b01;

  assign cfg_lenrow      = word[8:0];
  assign cfg_depblk      = word[16:9];
  assign cfg_numblk      = word[25:17];
  assign cfg_numfrm      = word[33:26];
  assign cfg_numpat      = word[38:34];
  assign cfg_numfilterg  = word[43:39];
  assign cfg_numlay      = word[48:44];
  assign cfg_prio        = word[52:49];
  assign cfg_stride      = word[54:53];
  assign cfg_pool_valifm = word[56:55];
  assign cfg_fl          = word[58:57];

endmodule

// File: tb/tb_cfg_fetch.sv
// Randomized bench for cfg_fetch: each transaction is described as a per-cycle
// timeline of expected outputs; a negedge process compares the DUT against it.
module tb_cfg_fetch;
  localparam int          AW   = 32;
  localparam int          DW   = 64;
  localparam int          IW   = 8;
  localparam int          T    = 1024;
  localparam logic [31:0] BASE = 32'h0800_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          cfg_req = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic          cfg_busy, cfg_vld, cfg_err;
  logic [8:0]    cfg_lenrow, cfg_numblk;
  logic [7:0]    cfg_depblk, cfg_numfrm;
  logic [4:0]    cfg_numpat, cfg_numfilterg, cfg_numlay;
  logic [3:0]    cfg_prio;
  logic [1:0]    cfg_stride, cfg_pool_valifm, cfg_fl;

  cfg_fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  cfg_fetch #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CFG_BASE(BASE), .IDX_WIDTH(IW), .TIMEOUT_CYC(T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_req(cfg_req), .cfg_idx(cfg_idx),
    .cfg_busy(cfg_busy), .cfg_vld(cfg_vld), .cfg_err(cfg_err),
    .cfg_lenrow(cfg_lenrow), .cfg_depblk(cfg_depblk), .cfg_numblk(cfg_numblk),
    .cfg_numfrm(cfg_numfrm), .cfg_numpat(cfg_numpat), .cfg_numfilterg(cfg_numfilterg),
    .cfg_numlay(cfg_numlay), .cfg_prio(cfg_prio), .cfg_stride(cfg_stride),
    .cfg_pool_valifm(cfg_pool_valifm), .cfg_fl(cfg_fl), .axi(axi)
  );

  int tests = 0;
  int fails = 0;

  logic        chk_en = 1'b0;
  logic        exp_busy, exp_arv, exp_rr, exp_vld, exp_err;
  logic [31:0] exp_addr;
  logic [58:0] exp_fields;
  logic [63:0] mem [256];
  logic [31:0] last_addr;
  int          n_r;

  logic [58:0] dut_fields;
  assign dut_fields = {cfg_fl, cfg_pool_valifm, cfg_stride, cfg_prio, cfg_numlay,
                       cfg_numfilterg, cfg_numpat, cfg_numfrm, cfg_numblk,
                       cfg_depblk, cfg_lenrow};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", cfg_busy, exp_busy);
      check("arvalid", axi.m_arvalid, exp_arv);
      check("rready", axi.m_rready, exp_rr);
      check("vld", cfg_vld, exp_vld);
      check("err", cfg_err, exp_err);
      check("fields", dut_fields, exp_fields);
      check("arconst", {axi.m_arlen, axi.m_arsize, axi.m_arburst}, {8'd0, 3'd3, 2'b01});
      if (exp_arv) check("araddr", axi.m_araddr, exp_addr);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input bit b, input bit a, input bit r, input bit v, input bit e);
    exp_busy = b; exp_arv = a; exp_rr = r; exp_vld = v; exp_err = e;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      cycle();
      cfg_req        = 1'b0;
      axi.m_arready  = 1'($urandom);
      axi.m_rvalid   = 1'($urandom);
      axi.m_rdata    = {$urandom, $urandom};
      axi.m_rresp    = 2'b00;
      set_exp(0, 0, 0, 0, 0);
    end
  endtask

  // One request: IDLE accept, aw AR wait cycles, rw R wait cycles, then DONE/ERR.
  // aw or rw >= T means the slave never responds on that channel.
  task automatic run_txn(input logic [7:0] idx, input int aw, input int rw,
                         input logic [1:0] resp, input bit hold);
    bit arok = 0;
    bit ok   = 0;
    cycle();
    cfg_req       = 1'b1;
    cfg_idx       = idx;
    axi.m_arready = 1'b0;
    axi.m_rvalid  = 1'b0;
    set_exp(0, 0, 0, 0, 0);
    exp_addr = BASE + 32'(idx) * 32'd8;
    n_r = 0;
    for (int i = 0; i < T; i++) begin
      cycle();
      if (i == 0) last_addr = axi.m_araddr;
      cfg_req       = hold;
      cfg_idx       = 8'($urandom);
      axi.m_arready = (i == aw);
      axi.m_rvalid  = 1'b0;
      set_exp(1, 1, 0, 0, 0);
      if (i == aw) begin
        arok = 1;
        break;
      end
    end
    if (arok) begin
      for (int j = 0; j < T; j++) begin
        cycle();
        cfg_idx       = 8'($urandom);
        axi.m_arready = 1'b0;
        axi.m_rvalid  = (j == rw);
        axi.m_rdata   = (j == rw) ? mem[idx] : {$urandom, $urandom};
        axi.m_rresp   = (j == rw) ? resp : 2'($urandom);
        axi.m_rlast   = 1'b1;
        set_exp(1, 0, 1, 0, 0);
        n_r++;
        if (j == rw) break;
      end
      ok = (rw < T) && (resp == 2'b00);
    end
    cycle();
    axi.m_arready = 1'b0;
    axi.m_rvalid  = 1'b0;
    if (ok) exp_fields = mem[idx][58:0];
    set_exp(1, 0, 0, ok, !ok);
  endtask

  initial begin
    axi.m_arready = 1'b0;
    axi.m_rvalid  = 1'b0;
    axi.m_rdata   = '0;
    axi.m_rresp   = 2'b00;
    axi.m_rlast   = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
    mem[0] = {5'b10101, 2'd3, 2'd2, 2'd0, 4'd15, 5'd31, 5'd1, 5'd15, 8'd15, 9'd7, 8'd7, 9'd10};

    #2 rst_n = 1'b0;
    repeat (3) cycle();
    check("rst_outs", {cfg_busy, cfg_vld, cfg_err, axi.m_arvalid, axi.m_rready}, 0);
    check("rst_fields", dut_fields, 0);
    check("rst_addr", axi.m_araddr, 0);
    rst_n = 1'b1;
    exp_fields = '0;
    set_exp(0, 0, 0, 0, 0);
    chk_en = 1'b1;
    idle(2);

    // Slot 0, zero-wait slave.
    run_txn(8'd0, 0, 0, 2'b00, 0);
    check("slot0_addr", last_addr, 32'h0800_0000);
    check("slot0_vld", cfg_vld, 1);
    check("lenrow", cfg_lenrow, 10);
    check("depblk", cfg_depblk, 7);
    check("numblk", cfg_numblk, 7);
    check("numfrm", cfg_numfrm, 15);
    check("numpat", cfg_numpat, 15);
    check("numfilterg", cfg_numfilterg, 1);
    check("numlay", cfg_numlay, 31);
    check("prio", cfg_prio, 15);
    check("stride", cfg_stride, 0);
    check("valifm", cfg_pool_valifm, 2);
    check("fl", cfg_fl, 3);
    idle(2);

    // Last slot, arready delayed 5 cycles.
    run_txn(8'd255, 5, 0, 2'b00, 0);
    check("slot255_addr", last_addr, 32'h0800_07F8);
    idle(1);

    // SLVERR on the beat: fields must keep slot 255 contents.
    run_txn(8'd17, 1, 2, 2'b10, 0);
    check("slverr_err", cfg_err, 1);
    check("slverr_vld", cfg_vld, 0);
    check("slverr_keep", cfg_numfrm, mem[255][33:26]);
    idle(1);

    // R-channel timeout, then a normal fetch.
    run_txn(8'd3, 0, T, 2'b00, 0);
    check("rtimeout_cycles", n_r, T);
    run_txn(8'd4, 0, 1, 2'b00, 0);
    idle(1);

    // AR-channel timeout.
    run_txn(8'd5, T, 0, 2'b00, 0);
    idle(1);

    // cfg_req held high: back-to-back, one AR per IDLE visit.
    for (int k = 0; k < 4; k++) run_txn(8'(10 + k), k, 3 - k, 2'b00, 1);
    idle(2);

    for (int k = 0; k < 40; k++) begin
      logic [1:0] rs;
      bit         hd;
      rs = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      hd = 1'($urandom);
      run_txn(8'($urandom), $urandom_range(0, 4), $urandom_range(0, 4), rs, hd);
      if (!hd) idle($urandom_range(0, 2));
    end
    idle(2);

    // Reset while in R with a stale rvalid arriving afterwards.
    cycle();
    cfg_req = 1'b1;
    cfg_idx = 8'd9;
    set_exp(0, 0, 0, 0, 0);
    exp_addr = BASE + 32'd72;
    cycle();
    cfg_req       = 1'b0;
    axi.m_arready = 1'b1;
    set_exp(1, 1, 0, 0, 0);
    cycle();
    axi.m_arready = 1'b0;
    set_exp(1, 0, 1, 0, 0);
    #2;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("midrst_outs", {cfg_busy, cfg_vld, cfg_err, axi.m_arvalid, axi.m_rready}, 0);
    check("midrst_fields", dut_fields, 0);
    check("midrst_addr", axi.m_araddr, 0);
    axi.m_rvalid = 1'b1;
    axi.m_rdata  = mem[9];
    axi.m_rresp  = 2'b00;
    cycle();
    rst_n = 1'b1;
    exp_fields = '0;
    set_exp(0, 0, 0, 0, 0);
    chk_en = 1'b1;
    repeat (3) cycle();
    axi.m_rvalid = 1'b0;
    run_txn(8'd9, 0, 0, 2'b00, 0);
    check("postrst_numblk", cfg_numblk, mem[9][25:17]);
    idle(2);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $fatal(1);
  end
endmodule
